// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and the
// instruction memory (slave).
//
// Handshake: IMEM_REQ/IMEM_ADDR are driven by the master. A transfer completes
// on a rising clock edge where IMEM_REQ=1 and IMEM_VALID=1; IMEM_RDATA is only
// meaningful on that edge. While IMEM_REQ=1 and IMEM_VALID=0 the master keeps
// IMEM_ADDR stable. IMEM_VALID is only asserted while IMEM_REQ=1.
interface instruction_fetch_stage_if #(
  parameter int ADDR_W = 32
) ();
  logic              IMEM_REQ;
  logic [ADDR_W-1:0] IMEM_ADDR;
  logic [31:0]       IMEM_RDATA;
  logic              IMEM_VALID;

  modport master (output IMEM_REQ, output IMEM_ADDR, input IMEM_RDATA, input IMEM_VALID);
  modport slave  (input IMEM_REQ, input IMEM_ADDR, output IMEM_RDATA, output IMEM_VALID);
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over the
// req/valid bus, registers it into IR_instruction for the decoder, applies
// execute-stage redirects and absorbs decoder back-pressure with a one-entry
// skid buffer. Optional feature macro: REDIRECT_COUNT_EN adds a 16-bit
// wrapping REDIRECT_COUNT output.
// DBG_STATE encoding: 0 IDLE, 1 FETCH, 2 HOLD, 3 DRAIN.
module instruction_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  instruction_fetch_stage_if.master  imem,
  input  logic                       STALL,
  input  logic                       EX_VALID,
  input  logic [1:0]                 BS,
  input  logic                       PS,
  input  logic                       Z,
  input  logic [ADDR_W-1:0]          BRANCH_TARGET,
  input  logic [ADDR_W-1:0]          RAA,
  output logic [31:0]                IR_instruction,
  output logic [ADDR_W-1:0]          PC_1,
  output logic                       IF_VALID,
`ifdef REDIRECT_COUNT_EN
  output logic [15:0]                REDIRECT_COUNT,
`endif
  output logic [1:0]                 DBG_STATE
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DRAIN = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_q, req_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] pc1_q, pc1_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       skid_q, skid_d;
  logic [ADDR_W-1:0] skid_pc1_q, skid_pc1_d;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;

  // Decode the execute-stage outcome into a redirect request and its target.
  always_comb begin
    redirect = EX_VALID & (((BS == 2'b01) & (Z ^ PS)) | (BS == 2'b10) | (BS == 2'b11));
    target   = (BS == 2'b10) ? RAA : BRANCH_TARGET;
    pc_inc   = pc_q + ADDR_W'(1);
  end

  // Next-state logic: fetch/skid sequencing first, then redirect overrides it.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    pc1_d      = pc1_q;
    if_valid_d = if_valid_q;
    skid_d     = skid_q;
    skid_pc1_d = skid_pc1_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem.IMEM_VALID) begin
          pc_d = pc_inc;
          if (!if_valid_q || !STALL) begin
            ir_d       = imem.IMEM_RDATA;
            pc1_d      = pc_inc;
            if_valid_d = 1'b1;
          end else begin
            // Decoder is full: park the word until it frees up.
            skid_d     = imem.IMEM_RDATA;
            skid_pc1_d = pc_inc;
            state_d    = HOLD;
          end
        end else if (!STALL) begin
          if_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (!STALL) begin
          ir_d       = skid_q;
          pc1_d      = skid_pc1_q;
          if_valid_d = 1'b1;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        // Wrong-path response still owed by memory; swallow it.
        if (imem.IMEM_VALID) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      pc_d       = target;
      if_valid_d = 1'b0;
      ir_d       = '0;
      if (state_q == FETCH && !imem.IMEM_VALID) begin
        state_d = DRAIN;
      end else if (state_q != DRAIN) begin
        state_d = FETCH;
      end
    end
    req_d      = (state_d == FETCH) || (state_d == DRAIN);
    // The outstanding address is frozen while draining; otherwise it tracks PC.
    req_addr_d = (state_d == DRAIN) ? req_addr_q : pc_d;
  end

  // Register all stage state; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      req_q      <= 1'b0;
      ir_q       <= '0;
      pc1_q      <= '0;
      if_valid_q <= 1'b0;
      skid_q     <= '0;
      skid_pc1_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      req_q      <= req_d;
      ir_q       <= ir_d;
      pc1_q      <= pc1_d;
      if_valid_q <= if_valid_d;
      skid_q     <= skid_d;
      skid_pc1_q <= skid_pc1_d;
    end
  end

`ifdef REDIRECT_COUNT_EN
  logic [15:0] rc_q, rc_d;

  // Count redirect cycles, wrapping at 16 bits.
  always_comb begin
    rc_d = redirect ? rc_q + 16'd1 : rc_q;
  end

  // Redirect counter register.
  always_ff @(posedge CLK) begin
    if (RESET) rc_q <= '0;
    else       rc_q <= rc_d;
  end

  assign REDIRECT_COUNT = rc_q;
`endif

  assign imem.IMEM_REQ  = req_q;
  assign imem.IMEM_ADDR = req_addr_q;
  assign IR_instruction = ir_q;
  assign PC_1           = pc1_q;
  assign IF_VALID       = if_valid_q;
  assign DBG_STATE      = state_q;

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Holds the program counter and requests instructions from instruction memory using a req/valid handshake.
- Registers each returned word into IR_instruction, which the decoder consumes.
- Applies redirects from the execute-stage BS/PS/Z outcome (branch, jump, jump-register), squashes wrong-path fetches, and stalls under downstream back-pressure through a one-entry skid buffer.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
ADDR_W, 32, PC / instruction-memory address width.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
IMEM_REQ  output  1  fetch request to instruction memory.
IMEM_ADDR  output  ADDR_W  word address of the request (= PC).
IMEM_RDATA  input  32  returned instruction word.
IMEM_VALID  input  1  IMEM_RDATA valid; only asserted while IMEM_REQ=1.
STALL  input  1  decoder/pipeline cannot accept a new instruction this cycle.
EX_VALID  input  1  BS/PS/Z/targets below are valid this cycle.
BS  input  2  branch select from decoded control word: 00 none, 01 conditional, 10 jump-register, 11 jump.
PS  input  1  polarity: 0 = branch on Z=1, 1 = branch on Z=0.
Z  input  1  zero flag from execute.
BRANCH_TARGET  input  ADDR_W  target address for BS=01 (taken) and BS=11.
RAA  input  ADDR_W  register A value; target address for BS=10.
IR_instruction  output  32  registered instruction to the decoder.
PC_1  output  ADDR_W  address of IR_instruction + 1 (link value for JML).
IF_VALID  output  1  IR_instruction holds a live instruction.

Behaviour:
- REDIRECT = EX_VALID & ((BS==01 & (Z^PS)) | BS==10 | BS==11). Target: RAA if BS==10, else BRANCH_TARGET.
- States: IDLE, FETCH, HOLD, DRAIN. IMEM_REQ = (state==FETCH | state==DRAIN). IMEM_ADDR = PC. IMEM_ADDR must stay stable while IMEM_REQ=1 and IMEM_VALID=0.
- Reset (priority over everything):
  - PC=RESET_PC, IR_instruction=0, PC_1=0, IF_VALID=0, skid empty, state=IDLE.
  - IMEM_REQ is therefore 0.
- IDLE: unconditionally goes to FETCH on the next cycle. The first request appears 1 cycle after RESET deasserts.
- FETCH, IMEM_VALID=1, no redirect:
  - PC<=PC+1.
  - If output slot free (IF_VALID=0 or STALL=0): IR_instruction<=IMEM_RDATA, PC_1<=PC+1, IF_VALID<=1, stay FETCH. Back-to-back fetch gives 1 instruction/cycle with zero-wait memory.
  - Else: skid<=IMEM_RDATA, skid_pc1<=PC+1, state->HOLD.
- FETCH, IMEM_VALID=0, no redirect: hold. If STALL=0, IF_VALID<=0, because the decoder consumed the instruction.
- HOLD: IMEM_REQ=0. When STALL=0: IR_instruction<=skid, PC_1<=skid_pc1, IF_VALID<=1, state->FETCH.
- Redirect (priority over STALL, applies in any state):
  - PC<=target, IF_VALID<=0, IR_instruction<=0, skid discarded.
  - If state==FETCH and IMEM_VALID=0 (request outstanding): state->DRAIN.
  - Otherwise (including redirect coincident with IMEM_VALID): state->FETCH and the returned word is discarded.
- DRAIN: IMEM_REQ held, IMEM_ADDR = old outstanding address. This requires a separate registered request address; PC already holds the target. On IMEM_VALID: discard data, state->FETCH. A further redirect during DRAIN only updates PC.
- Redirect penalty with zero-wait memory: first target instruction is in IR 2 cycles after the EX_VALID cycle.
- PC arithmetic is modulo 2^ADDR_W: PC 0xFFFFFFFF + 1 wraps to 0 without error.
- Not-taken conditional (BS=01, Z^PS=0) and BS=00 have no effect on PC or state.

Optional Feature:
- Macro REDIRECT_COUNT_EN.
- Defined: adds output REDIRECT_COUNT [15:0], reset to 0, incremented by 1 on every REDIRECT cycle, wraps 0xFFFF->0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then release, zero-wait memory returning addr as data -> IMEM_REQ rises 1 cycle after release; IR_instruction = 0, 1, 2 on consecutive cycles; PC_1 = 1, 2, 3; IF_VALID=1 from the first capture.
- STALL=1 for 3 cycles while IR=5 and the fetch of 6 completes -> IR holds 5, state HOLD, IMEM_REQ=0; STALL drops -> IR=6 next cycle, then 7.
- EX_VALID, BS=01, PS=0, Z=1, BRANCH_TARGET=0x40 -> IF_VALID=0 next cycle, IMEM_ADDR=0x40, IR=0x40 2 cycles after; same with Z=0 -> no redirect.
- Memory with 3-cycle latency, redirect BS=10, RAA=0x100 during an outstanding fetch of 0x8 -> IMEM_ADDR stays 0x8 until VALID, that data is discarded, then request 0x100.
- RESET asserted during HOLD with redirect pending -> all outputs return to reset values, PC=RESET_PC. REDIRECT_COUNT_EN build: 3 redirects -> REDIRECT_COUNT=3; reset -> 0.
